vga_frame_reader: RTL and testbench
===================================

// Module: vga_frame_reader
// PURPOSE
// - Downstream consumer of the dual-port frame buffer's read port. Generates 640x480@60 VGA timing
//   and scans the buffer, one address per displayed image pixel.
// - Drives the buffer's read address and accepts its registered read data, then outputs RGB and sync to the DAC/pins.
// - Stores an IMG_W x IMG_H image and shows it in the top-left corner, replicated SCALE x SCALE; the rest of the screen is black.
// PARAMETERS
// - AW      15   read address width; must match the buffer; IMG_W*IMG_H <= 2**AW
// - DW      12   pixel width, RGB packed {R,G,B}; each channel is DW/3 bits
// - IMG_W   160  stored image width in pixels
// - IMG_H   120  stored image height in pixels
// - SCALE   4    pixel replication factor; 1, 2 or 4 only
// - H_ACT/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal timing in clocks
// - V_ACT/V_FP/V_SYNC/V_BP  480/10/2/33   vertical timing in lines
// PORTS
// - clk          in   1     pixel clock (25 MHz); the buffer's clk_r is tied to this clock
// - reset        in   1     asynchronous, active-high
// - rd_addr      out  AW    to the buffer's addr_out
// - rd_data      in   DW    from the buffer's data_out; valid 1 clk after rd_addr
// - vga_hs       out  1     hsync, active-low
// - vga_vs       out  1     vsync, active-low
// - vga_r/g/b    out  DW/3  colour channels; 0 during blanking and outside the image window
// - frame_start  out  1     1-clk pulse aligned with pixel (0,0) on the outputs
// BEHAVIOUR
// - One clock domain, clk. Reset is asynchronous, active-high.
// - Reset values: h_cnt=0, v_cnt=0, rd_addr=0, vga_hs=1, vga_vs=1, rgb=0, frame_start=0, pipeline regs cleared.
// - Counters
//   - h_cnt runs 0..H_TOTAL-1 (800) and wraps to 0.
//   - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 (525) and wraps to 0.
// - Timing regions
//   - Active: h<H_ACT && v<V_ACT.
//   - hs low for H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC.
//   - vs low for V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC.
// - Window: in_img = h<IMG_W*SCALE && v<IMG_H*SCALE.
// - Addressing, no multiplier
//   - row_base is cleared at v=0.
//   - When h wraps and the next v is inside the window and (v+1)%SCALE==0, row_base += IMG_W.
//   - Address = row_base + (h>>log2(SCALE)).
// - Pipeline, 3 clk from counters to pins
//   - S0: counters.
//   - S1: rd_addr registered; rd_addr=0 when !in_img.
//   - S2: the buffer returns rd_data.
//   - S3: output regs capture rgb = in_img_d2 ? rd_data split : 0.
//   - hs, vs, de, in_img and frame_start are delayed so they align with S3.
// - Channel split: r=rd_data[DW-1 -: DW/3], g=middle third, b=[DW/3-1:0].
// - Boundaries
//   - Last address of a frame is IMG_W*IMG_H-1.
//   - row_base never exceeds (IMG_H-1)*IMG_W; it holds outside the window and resets at the frame wrap.
//   - Reset mid-frame: everything clears immediately. Timing restarts at (0,0) on the first clk after release.
//   - First frame_start appears 3 clk after release.
//   - rd_data is ignored whenever in_img_d2=0, so stale buffer data never reaches the pins.
//   - Writes to the buffer during scan-out are permitted; no tearing protection is provided.
// STRUCTURE
// - Shared include vga_params.vh: 640x480 timing constants, H_TOTAL=800, V_TOTAL=525, sync polarity.
// - Sub-module vga_sync_gen: h/v counters, hs/vs, active flag. The top holds the address generator
//   and the alignment pipeline.
// TESTING
// - Release reset, run 1 frame:
//   - first frame_start at clk 3 after release;
//   - next frame_start exactly 420000 clk later.
// - hs: low width 96 clk, period 800, falling edge at h=656+3 clk.
// - vs: low for 2 lines (1600 clk) starting at line 490.
// - Stub the buffer as data=addr[11:0]:
//   - line 0 pixels 0..3 show 0x000, pixels 4..7 show 0x001;
//   - line 4 pixel 0 shows 0x0A0 (addr 160);
//   - last image pixel (639,479) shows addr 19199 -> 0xAFF.
// - Pixels h>=640 or v>=480 (blanking) output rgb=0. With the stub driving 0xFFF constantly,
//   rgb is 0 in blanking and 0xFFF only inside the window.
// - Assert reset at line 200 pixel 300 for 5 clk:
//   - outputs go to reset values immediately;
//   - after release, timing restarts from (0,0);
//   - rd_addr for the first window pixel is 0.

Source files
------------

// File: rtl/vga_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// vga_frame_reader_pkg
// Shared definitions for the VGA frame reader:
//   - default 640x480@60 timing constants (clocks per line, lines per frame)
//   - sync polarity (both syncs active-low)
//   - the control tag carried alongside each pixel through the read pipeline
// No ports; imported by vga_sync_gen and vga_frame_reader.
// -----------------------------------------------------------------------------
package vga_frame_reader_pkg;

   // Counter width large enough for both 800 clocks/line and 525 lines/frame.
   localparam int CNT_W = 10;

   localparam int H_ACT_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_ACT_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   localparam int H_TOTAL_DEF = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
   localparam int V_TOTAL_DEF = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

   // Level driven on hs/vs while inside the sync pulse.
   localparam logic SYNC_ACTIVE = 1'b0;

   // Per-pixel control flags that travel with the read request so they line
   // up with the data returned by the frame buffer.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic in_img;
      logic fs;
   } pipe_tag_t;

   localparam pipe_tag_t TAG_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE,
                                      de: 1'b0, in_img: 1'b0, fs: 1'b0};

   // Size an integer timing constant to the counter width.
   function automatic logic [CNT_W-1:0] cnt(input int value);
      return CNT_W'(value);
   endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Horizontal/vertical raster counters and the sync/active decodes derived
// from them. All outputs describe the pixel currently addressed by the
// counters (pipeline stage 0); the caller delays them as needed.
// Ports:
//   clk        in   pixel clock
//   reset      in   asynchronous, active-high
//   h_cnt      out  CNT_W  column, 0..H_TOTAL-1
//   v_cnt      out  CNT_W  line, 0..V_TOTAL-1
//   hs         out  1      horizontal sync (SYNC_ACTIVE during the pulse)
//   vs         out  1      vertical sync (SYNC_ACTIVE during the pulse)
//   de         out  1      inside the visible area
//   line_end   out  1      last column of a line
//   frame_end  out  1      last column of the last line
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_frame_reader_pkg::*;
#(
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic             line_end,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] H_LAST     = cnt(H_ACT + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST     = cnt(V_ACT + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] H_VIS      = cnt(H_ACT);
   localparam logic [CNT_W-1:0] V_VIS      = cnt(V_ACT);
   localparam logic [CNT_W-1:0] HS_START   = cnt(H_ACT + H_FP);
   localparam logic [CNT_W-1:0] HS_END     = cnt(H_ACT + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = cnt(V_ACT + V_FP);
   localparam logic [CNT_W-1:0] VS_END     = cnt(V_ACT + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] CNT_ONE    = cnt(1);

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);

   assign hs = (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vs = (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign de = (h_cnt < H_VIS) && (v_cnt < V_VIS);

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= frame_end ? '0 : v_cnt + CNT_ONE;
      end else begin
         h_cnt <= h_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
// Scans a stored IMG_W x IMG_H image out of a dual-port frame buffer and
// shows it, replicated SCALE x SCALE, in the top-left corner of a VGA raster.
// Everything outside the image window, and all blanking, is black.
// Pipeline (3 clocks from counters to pins):
//   S0 counters -> S1 rd_addr register -> S2 buffer returns rd_data
//   -> S3 output registers (rgb, syncs, frame_start).
// Ports:
//   clk          in   pixel clock, shared with the buffer read port
//   reset        in   asynchronous, active-high
//   rd_addr      out  AW    buffer read address
//   rd_data      in   DW    buffer read data, valid 1 clk after rd_addr
//   vga_hs       out  1     hsync, active-low
//   vga_vs       out  1     vsync, active-low
//   vga_r/g/b    out  DW/3  colour channels
//   frame_start  out  1     1-clk pulse with pixel (0,0) on the outputs
// -----------------------------------------------------------------------------
module vga_frame_reader
   import vga_frame_reader_pkg::*;
#(
   parameter int AW     = 15,
   parameter int DW     = 12,
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int SCALE  = 4,
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic            clk,
   input  logic            reset,
   output logic [AW-1:0]   rd_addr,
   input  logic [DW-1:0]   rd_data,
   output logic            vga_hs,
   output logic            vga_vs,
   output logic [DW/3-1:0] vga_r,
   output logic [DW/3-1:0] vga_g,
   output logic [DW/3-1:0] vga_b,
   output logic            frame_start
);

   localparam int CW = DW / 3;
   localparam int SH = $clog2(SCALE);

   localparam logic [CNT_W-1:0] WIN_W    = cnt(IMG_W * SCALE);
   localparam logic [CNT_W-1:0] WIN_H    = cnt(IMG_H * SCALE);
   localparam logic [CNT_W-1:0] SC_MASK  = cnt(SCALE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = cnt(1);
   localparam logic [AW-1:0]    ROW_STEP = AW'(IMG_W);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic [CNT_W-1:0] v_next;
   logic             hs;
   logic             vs;
   logic             de;
   logic             line_end;
   logic             frame_end;
   logic             in_img;
   logic             show;
   logic [AW-1:0]    row_base;
   logic [AW-1:0]    pix_addr;
   pipe_tag_t        tag_s0;
   pipe_tag_t        tag_d1;
   pipe_tag_t        tag_d2;

   vga_sync_gen #(
      .H_ACT  (H_ACT),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_ACT  (V_ACT),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .hs        (hs),
      .vs        (vs),
      .de        (de),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   // Stage-0 decode. The image address is row_base (start of the current
   // stored row) plus the column divided by SCALE, so no multiplier is needed.
   always_comb begin
      // NOTE: every signal gets a default before any condition so this block
      // can never infer a latch.
      in_img   = 1'b0;
      v_next   = '0;
      pix_addr = '0;
      tag_s0   = TAG_IDLE;
      show     = 1'b0;

      in_img        = (h_cnt < WIN_W) && (v_cnt < WIN_H);
      v_next        = v_cnt + CNT_ONE;
      pix_addr      = row_base + AW'(h_cnt >> SH);
      tag_s0.hs     = hs;
      tag_s0.vs     = vs;
      tag_s0.de     = de;
      tag_s0.in_img = in_img;
      tag_s0.fs     = (h_cnt == '0) && (v_cnt == '0);
      show          = tag_d2.in_img && tag_d2.de;
   end

   // Row base steps by one stored row each time SCALE screen lines of the
   // window have been shown; it holds below the window and clears at frame wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_base <= '0;
      end else if (line_end) begin
         if (frame_end) begin
            row_base <= '0;
         end else if (v_next < WIN_H && (v_next & SC_MASK) == '0) begin
            row_base <= row_base + ROW_STEP;
         end
      end
   end

   // S1 issues the read; S2 waits for the buffer's registered data; S3 drives
   // the pins. Outside the window the address parks at 0 and the returned data
   // is discarded, so stale buffer contents never reach the DAC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_addr     <= '0;
         tag_d1      <= TAG_IDLE;
         tag_d2      <= TAG_IDLE;
         vga_hs      <= ~SYNC_ACTIVE;
         vga_vs      <= ~SYNC_ACTIVE;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         frame_start <= 1'b0;
      end else begin
         rd_addr     <= in_img ? pix_addr : '0;
         tag_d1      <= tag_s0;
         tag_d2      <= tag_d1;
         vga_hs      <= tag_d2.hs;
         vga_vs      <= tag_d2.vs;
         vga_r       <= show ? rd_data[DW-1 -: CW]   : '0;
         vga_g       <= show ? rd_data[2*CW-1 -: CW] : '0;
         vga_b       <= show ? rd_data[CW-1:0]       : '0;
         frame_start <= tag_d2.fs;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_reader
// Scoreboard bench for vga_frame_reader with a shortened raster (80 x 55
// clocks, 48 x 40 image window) so several frames fit in a short run.
// A frame-buffer stub with random contents answers reads one clock late.
// Each clock, the expected outputs are computed from the raster position
// (plain div/mod arithmetic) and queued; a monitor on the falling edge pops
// and compares them against the pins.
// -----------------------------------------------------------------------------
module tb_vga_frame_reader;

   localparam int AW     = 8;
   localparam int DW     = 12;
   localparam int IMG_W  = 12;
   localparam int IMG_H  = 10;
   localparam int SCALE  = 4;
   localparam int H_ACT  = 64;
   localparam int H_FP   = 4;
   localparam int H_SYNC = 8;
   localparam int H_BP   = 4;
   localparam int V_ACT  = 48;
   localparam int V_FP   = 2;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 3;
   localparam int HT     = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int VT     = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int FRAME  = HT * VT;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          hs;
      logic          vs;
      logic [DW-1:0] rgb;
      logic          fs;
   } exp_t;

   logic            clk;
   logic            reset;
   logic [AW-1:0]   rd_addr;
   logic [DW-1:0]   rd_data;
   logic            vga_hs;
   logic            vga_vs;
   logic [DW/3-1:0] vga_r;
   logic [DW/3-1:0] vga_g;
   logic [DW/3-1:0] vga_b;
   logic            frame_start;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   exp_t          exp_q[$];
   int            k;
   int            last_fs;
   int            n_cmp;
   int            n_bad;

   vga_frame_reader #(
      .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE),
      .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame buffer read port: registered read, data one clock after address.
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at k=%0d: got 0x%0h expected 0x%0h", name, k, got, want);
      end
   endtask

   function automatic bit in_window(int h, int v);
      return (h < IMG_W * SCALE) && (v < IMG_H * SCALE) && (h < H_ACT) && (v < V_ACT);
   endfunction

   function automatic int img_addr(int h, int v);
      return (v / SCALE) * IMG_W + (h / SCALE);
   endfunction

   // Expected pins after k clock edges since reset release.
   function automatic exp_t model(int kk);
      exp_t e;
      int   p, h, v;
      e = '{addr: '0, hs: 1'b1, vs: 1'b1, rgb: '0, fs: 1'b0};
      if (kk >= 1) begin
         p = kk - 1;
         h = p % HT;
         v = (p / HT) % VT;
         if (in_window(h, v)) e.addr = AW'(img_addr(h, v));
      end
      if (kk >= 3) begin
         p = kk - 3;
         h = p % HT;
         v = (p / HT) % VT;
         e.hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYNC);
         e.vs = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYNC);
         e.fs = (h == 0) && (v == 0);
         if (in_window(h, v)) e.rgb = mem[img_addr(h, v)];
      end
      return e;
   endfunction

   // Scoreboard producer: advance the raster position and queue the expectation.
   always @(posedge clk) begin
      if (reset) k = 0;
      else       k = k + 1;
      exp_q.push_back(model(k));
   end

   // Scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_empty at k=%0d: got 0 entries expected 1", k);
      end else begin
         e = exp_q.pop_front();
         check("rd_addr", 32'(rd_addr), 32'(e.addr));
         check("hs_vs", {30'd0, vga_hs, vga_vs}, {30'd0, e.hs, e.vs});
         check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
         check("frame_start", 32'(frame_start), 32'(e.fs));
      end
   end

   // Frame cadence: first pulse 3 clocks after release, then once per frame.
   always @(negedge clk) begin
      if (reset) begin
         last_fs = -1;
      end else if (frame_start) begin
         if (last_fs < 0) check("first_frame_start", 32'(k), 32'd3);
         else             check("frame_period", 32'(k - last_fs), 32'(FRAME));
         last_fs = k;
      end
   end

   task automatic fill_random();
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
   endtask

   task automatic fill_const(input logic [DW-1:0] value);
      for (int i = 0; i < (1 << AW); i++) mem[i] = value;
   endtask

   task automatic run_until(input int target);
      while (k < target) @(negedge clk);
   endtask

   // Assert reset just after a falling-edge sample, confirm the pins clear
   // without waiting for a clock, hold for the given clocks, then release.
   task automatic pulse_reset(input int hold, input bit const_fill, input logic [DW-1:0] value);
      #1 reset = 1'b1;
      #1;
      check("reset_immediate", {rd_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start},
            {{AW{1'b0}}, 1'b1, 1'b1, {DW{1'b0}}, 1'b0});
      if (const_fill) fill_const(value);
      else            fill_random();
      repeat (hold) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      k       = 0;
      last_fs = -1;
      reset   = 1'b1;
      fill_random();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;

      // Two frames of random image, then reset mid-frame (line 20, pixel 30).
      run_until(FRAME + 20 * HT + 30);
      @(negedge clk);
      pulse_reset(5, 1'b1, 12'hFFF);

      // Constant white buffer: window must be 0xFFF, everything else black.
      run_until(FRAME + 10 * HT);
      @(negedge clk);
      pulse_reset(2 + $urandom_range(0, 6), 1'b0, '0);

      // Fresh random image across two frame boundaries, then a random reset.
      run_until(2 * FRAME + $urandom_range(0, FRAME - 1));
      @(negedge clk);
      pulse_reset(3, 1'b0, '0);
      run_until(FRAME + 50);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
